// File: rtl/div_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master drives operands and start; the slave returns results and status.
interface div_if;
    logic       start;
    logic [7:0] in_lo;
    logic [7:0] in_hi;
    logic [7:0] in_b;
    logic [7:0] out_q;
    logic [7:0] out_r;
    logic       busy;
    logic       done;
    logic       div_zero;
    logic       overflow;

    modport master (
        output start, in_lo, in_hi, in_b,
        input  out_q, out_r, busy, done, div_zero, overflow
    );

    modport slave (
        input  start, in_lo, in_hi, in_b,
        output out_q, out_r, busy, done, div_zero, overflow
    );
endinterface

// File: rtl/div.sv
// Restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Operands with a zero divisor or a quotient wider than 8 bits are rejected in one cycle.
module div (
    input  logic clk,
    input  logic reset,
    div_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    state_t     state_nx;
    logic [8:0] rem;
    logic [7:0] quo;
    logic [7:0] dvs;
    logic [2:0] cnt;

    logic       accept;
    logic       err_zero;
    logic       err_ovf;
    logic [9:0] trial;
    logic [8:0] diff;
    logic [8:0] rem_nx;
    logic       bit_nx;

    // Operand screening happens on the live inputs in the acceptance cycle.
    assign accept   = (state == IDLE) && bus.start;
    assign err_zero = (bus.in_b == 8'd0);
    assign err_ovf  = !err_zero && (bus.in_hi >= bus.in_b);

    // One restoring step; rem[8] is always 0, but keeping it in the compare stays exact.
    assign trial  = {rem, quo[7]};
    assign diff   = trial[8:0] - {1'b0, dvs};
    assign bit_nx = (trial >= {2'b00, dvs});
    assign rem_nx = bit_nx ? diff : trial[8:0];

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && !err_zero && !err_ovf) state_nx = RUN;
            RUN:  if (cnt == 3'd7)                     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_q    <= 8'd0;
            bus.out_r    <= 8'd0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.overflow <= 1'b0;
            rem          <= 9'd0;
            quo          <= 8'd0;
            dvs          <= 8'd0;
            cnt          <= 3'd0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                if (err_zero || err_ovf) begin
                    bus.out_q    <= 8'hFF;
                    bus.out_r    <= 8'hFF;
                    bus.done     <= 1'b1;
                    bus.div_zero <= err_zero;
                    bus.overflow <= err_ovf;
                end else begin
                    rem          <= {1'b0, bus.in_hi};
                    quo          <= bus.in_lo;
                    dvs          <= bus.in_b;
                    cnt          <= 3'd0;
                    bus.div_zero <= 1'b0;
                    bus.overflow <= 1'b0;
                end
            end else if (state == RUN) begin
                rem <= rem_nx;
                quo <= {quo[6:0], bit_nx};
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    bus.out_q <= {quo[6:0], bit_nx};
                    bus.out_r <= rem_nx[7:0];
                    bus.done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed handshake cases plus a randomized sweep
// compared against plain integer division.
module tb_div;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    div_if bus ();

    div dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition of the operation.
    task automatic model(input logic [15:0] dvd, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
        int quot;
        dz = 1'b0; ov = 1'b0; q = 8'hFF; r = 8'hFF; lat = 1;
        if (b == 8'd0) begin
            dz = 1'b1;
        end else begin
            quot = int'(dvd) / int'(b);
            if (quot > 255) begin
                ov = 1'b1;
            end else begin
                q   = 8'(quot);
                r   = 8'(int'(dvd) % int'(b));
                lat = 9;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic do_op(input logic [15:0] dvd, input logic [7:0] b,
                         input int poke_at, input string tag);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         elat, cyc, busy_cnt;
        model(dvd, b, eq, er, edz, eov, elat);
        bus.start = 1'b1;
        bus.in_hi = dvd[15:8];
        bus.in_lo = dvd[7:0];
        bus.in_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_hi = 8'($urandom);
        bus.in_lo = 8'($urandom);
        bus.in_b  = 8'($urandom);
        cyc = 1;
        busy_cnt = 0;
        while (cyc <= 16 && !bus.done) begin
            if (bus.busy) busy_cnt++;
            if (cyc == poke_at) begin
                bus.start = 1'b1;
                bus.in_hi = 8'hFF;
                bus.in_lo = 8'hFF;
                bus.in_b  = 8'h01;
            end
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        if (bus.busy) busy_cnt++;
        check({tag, "_latency"}, bus.done ? cyc : 0, elat);
        check({tag, "_busy_cycles"}, busy_cnt, (elat == 9) ? 8 : 0);
        check({tag, "_q"}, bus.out_q, eq);
        check({tag, "_r"}, bus.out_r, er);
        check({tag, "_div_zero"}, bus.div_zero, edz);
        check({tag, "_overflow"}, bus.overflow, eov);
    endtask

    initial begin
        logic [15:0] dvd;
        logic [7:0]  b, a, rm;
        int          stray;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.in_hi = 8'd0;
        bus.in_lo = 8'd0;
        bus.in_b  = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_q", bus.out_q, 8'd0);
        check("rst_r", bus.out_r, 8'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_div_zero", bus.div_zero, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 8'h56, 0, "basic");
        check("basic_q_const", bus.out_q, 8'h36);
        check("basic_r_const", bus.out_r, 8'h10);
        @(negedge clk);

        do_op(16'hFE01, 8'hFF, 0, "max");
        do_op(16'h00FF, 8'h10, 0, "b2b");
        check("b2b_q_const", bus.out_q, 8'h0F);
        @(negedge clk);

        do_op(16'h0010, 8'h00, 0, "dz");
        @(negedge clk);
        do_op(16'h0100, 8'h01, 0, "ovf");
        @(negedge clk);

        do_op(16'h1234, 8'h56, 3, "busy_start");
        @(negedge clk);
        check("busy_start_single_done", bus.done, 1'b0);

        bus.start = 1'b1;
        bus.in_hi = 8'h12;
        bus.in_lo = 8'h34;
        bus.in_b  = 8'h56;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_q", bus.out_q, 8'd0);
        check("abort_r", bus.out_r, 8'd0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_flags", {bus.div_zero, bus.overflow}, 2'b00);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) stray++;
        end
        check("abort_no_done", stray, 0);
        do_op(16'h0064, 8'h07, 0, "after_abort");
        check("after_abort_q_const", bus.out_q, 8'h0E);
        check("after_abort_r_const", bus.out_r, 8'h02);

        for (int i = 0; i < 3000; i++) begin
            b   = 8'($urandom_range(1, 255));
            a   = 8'($urandom_range(0, 255));
            rm  = 8'($urandom_range(0, int'(b) - 1));
            dvd = 16'(int'(a) * int'(b) + int'(rm));
            do_op(dvd, b, 0, "rnd");
            check("rnd_invariant", 32'(int'(bus.out_q) * int'(b) + int'(bus.out_r)), 32'(dvd));
        end

        for (int i = 0; i < 300; i++) begin
            dvd = 16'($urandom);
            b   = (i % 10 == 0) ? 8'd0 : 8'($urandom);
            do_op(dvd, b, 0, "any");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
